// File: rtl/reg_xfer_ctrl.sv
// Five-state sequencer that turns a single-port 8x16 register bank into a
// three-operand (rd <- rs1 op rs2) datapath. Optional flags: REG_XFER_FLAGS_EN.
module reg_xfer_ctrl #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [WIDTH-1:0] bank_rdata,
  output logic [AW-1:0]    bank_addr,
  output logic             bank_rd,
  output logic             bank_wr,
  output logic [WIDTH-1:0] bank_wdata,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
`ifdef REG_XFER_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_c
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_EXEC, S_WB
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_MOV
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q;
  logic [AW-1:0]    rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] alu_res;

  // NOTE: state lives in always_ff with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Bank controls are pure decodes of state and captured fields, so an async
  // reset drops bank_wr at once and a reset during WB suppresses the write.
  always_comb begin
    // NOTE: every output gets a default first; a missed branch would
    // otherwise infer a latch.
    state_d    = state_q;
    bank_addr  = '0;
    bank_rd    = 1'b0;
    bank_wr    = 1'b0;
    bank_wdata = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RD1;
      S_RD1: begin
        bank_addr = rs1_q;
        bank_rd   = 1'b1;
        state_d   = S_RD2;
      end
      S_RD2: begin
        bank_addr = rs2_q;
        bank_rd   = 1'b1;
        state_d   = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        bank_addr  = rd_q;
        bank_wr    = 1'b1;
        bank_wdata = result;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_SHL:  alu_res = a_q << 1;
      default: alu_res = a_q;
    endcase
  end

`ifdef REG_XFER_FLAGS_EN
  logic alu_c;

  // Unsigned wrap check: a WIDTH-bit sum smaller than an addend means carry out.
  always_comb begin
    alu_c = 1'b0;
    case (op_q)
      OP_ADD:  alu_c = ((a_q + b_q) < a_q);
      OP_SUB:  alu_c = (a_q < b_q);
      OP_SHL:  alu_c = a_q[WIDTH-1];
      default: alu_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (state_q == S_EXEC) begin
      flag_z <= (alu_res == '0);
      flag_c <= alu_c;
    end
  end
`endif

  // NOTE: captured fields and operands are plain flops (no memory array), so
  // they are reset along with the control state for a deterministic restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_ADD;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state_q == S_WB);
      case (state_q)
        S_IDLE: if (start) begin
          op_q  <= op_e'(op);
          rd_q  <= rd;
          rs1_q <= rs1;
          rs2_q <= rs2;
        end
        S_RD1:  a_q    <= bank_rdata;
        S_RD2:  b_q    <= bank_rdata;
        S_EXEC: result <= alu_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: a bank model, a transaction-level
// reference model compared every cycle, and directed literal checks.
module tb_reg_xfer_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] bank_rdata;
  logic [2:0]  bank_addr;
  logic        bank_rd, bank_wr;
  logic [15:0] bank_wdata, result;
  logic        busy, done;
`ifdef REG_XFER_FLAGS_EN
  logic        flag_z, flag_c;
`endif

  reg_xfer_ctrl #(.WIDTH(16), .AW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rd(rd), .rs1(rs1),
    .rs2(rs2), .bank_rdata(bank_rdata), .bank_addr(bank_addr),
    .bank_rd(bank_rd), .bank_wr(bank_wr), .bank_wdata(bank_wdata),
    .result(result), .busy(busy), .done(done)
`ifdef REG_XFER_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Register bank: combinational read, write on rising edge; preload port for setup.
  logic [15:0] bank_mem [8];
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;

  assign bank_rdata = bank_rd ? bank_mem[bank_addr] : 16'h0000;

  always @(posedge clk) begin
    if (bank_wr)    bank_mem[bank_addr] <= bank_wdata;
    else if (pl_en) bank_mem[pl_addr]   <= pl_data;
  end

  // Reference model: the result is known the moment an op is accepted; only
  // its visibility is delayed (result after 3 edges, write after 4, done after).
  function automatic logic [16:0] model_alu(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int   ai, bi, r;
    logic c;
    ai = int'(a);
    bi = int'(b);
    c  = 1'b0;
    case (o)
      3'd0: begin r = ai + bi; c = (r > 65535); end
      3'd1: begin r = ai - bi; c = (ai < bi);   end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: r = 65535 - ai;
      3'd6: begin r = ai * 2; c = (ai >= 32768); end
      default: r = ai;
    endcase
    r = r & 32'hFFFF;
    return {c, r[15:0]};
  endfunction

  logic [15:0] model_regs [8];
  logic [2:0]  m_cycles;
  logic [2:0]  m_rd, m_rs1, m_rs2;
  logic [16:0] m_pend;
  logic [15:0] m_result;
  logic        m_done, m_fz, m_fc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cycles <= 3'd0;
      m_rd     <= 3'd0;
      m_rs1    <= 3'd0;
      m_rs2    <= 3'd0;
      m_pend   <= 17'd0;
      m_result <= 16'h0000;
      m_done   <= 1'b0;
      m_fz     <= 1'b0;
      m_fc     <= 1'b0;
    end else begin
      m_done <= (m_cycles == 3'd4);
      if (pl_en) model_regs[pl_addr] <= pl_data;
      if (m_cycles == 3'd4) model_regs[m_rd] <= m_pend[15:0];
      if (m_cycles == 3'd3) begin
        m_result <= m_pend[15:0];
        m_fz     <= (m_pend[15:0] == 16'h0000);
        m_fc     <= m_pend[16];
      end
      if (m_cycles == 3'd0) begin
        if (start) begin
          m_cycles <= 3'd1;
          m_rd     <= rd;
          m_rs1    <= rs1;
          m_rs2    <= rs2;
          m_pend   <= model_alu(op, model_regs[rs1], model_regs[rs2]);
        end
      end else begin
        m_cycles <= (m_cycles == 3'd4) ? 3'd0 : m_cycles + 3'd1;
      end
    end
  end

  logic [2:0]  exp_addr;
  logic        exp_rd, exp_wr, exp_busy;
  logic [15:0] exp_wdata;
  logic        bank_ok;
  logic        bank_chk_en;

  assign exp_busy  = (m_cycles != 3'd0);
  assign exp_rd    = (m_cycles == 3'd1) || (m_cycles == 3'd2);
  assign exp_wr    = (m_cycles == 3'd4);
  assign exp_addr  = (m_cycles == 3'd1) ? m_rs1 : (m_cycles == 3'd2) ? m_rs2 :
                     (m_cycles == 3'd4) ? m_rd : 3'd0;
  assign exp_wdata = exp_wr ? m_result : 16'h0000;

  always_comb begin
    bank_ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (bank_mem[i] !== model_regs[i]) bank_ok = 1'b0;
  end

  always @(negedge clk) begin
    check("busy", busy, exp_busy);
    check("done", done, m_done);
    check("bank_addr", bank_addr, exp_addr);
    check("bank_rd", bank_rd, exp_rd);
    check("bank_wr", bank_wr, exp_wr);
    check("bank_wdata", bank_wdata, exp_wdata);
    check("result", result, m_result);
`ifdef REG_XFER_FLAGS_EN
    check("flag_z", flag_z, m_fz);
    check("flag_c", flag_c, m_fc);
`endif
    if (bank_chk_en) check("bank_contents", bank_ok, 1'b1);
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Returns 1 time unit after the accepting edge, i.e. inside the RD1 cycle.
  task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    @(posedge clk); #1;
    start = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] init_vals [8];
    logic [2:0]  tbl_op  [4];
    logic [15:0] tbl_exp [4];
    int busy_cnt, done_cnt;

    reset = 1'b0; start = 1'b0; op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0;
    pl_en = 1'b0; pl_addr = 3'd0; pl_data = 16'h0000; bank_chk_en = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_bank_wr", bank_wr, 1'b0);
    #2 reset = 1'b0;

    init_vals[0] = 16'h0000; init_vals[1] = 16'h0003; init_vals[2] = 16'h0005;
    init_vals[3] = 16'h0000; init_vals[4] = 16'h0000; init_vals[5] = 16'hFFFF;
    init_vals[6] = 16'h0001; init_vals[7] = 16'h1234;
    for (int i = 0; i < 8; i++) preload(3'(i), init_vals[i]);
    bank_chk_en = 1'b1;

    // ADD R3 = R1 + R2, walking the cycle-by-cycle bank interface
    issue(3'b000, 3'd3, 3'd1, 3'd2);
    busy_cnt = 0;
    @(negedge clk);
    check("t1_rd1_addr", bank_addr, 3'd1); check("t1_rd1_rd", bank_rd, 1'b1);
    busy_cnt += int'(busy);
    @(negedge clk);
    check("t1_rd2_addr", bank_addr, 3'd2); busy_cnt += int'(busy);
    @(negedge clk);
    check("t1_exec_rd", bank_rd, 1'b0); check("t1_exec_wr", bank_wr, 1'b0);
    busy_cnt += int'(busy);
    @(negedge clk);
    check("t1_wb_addr", bank_addr, 3'd3); check("t1_wb_wr", bank_wr, 1'b1);
    check("t1_wb_wdata", bank_wdata, 16'h0008); busy_cnt += int'(busy);
    @(negedge clk);
    check("t1_done", done, 1'b1); check("t1_idle", busy, 1'b0);
    check("t1_r3", bank_mem[3], 16'h0008); check("t1_busy_cycles", busy_cnt, 4);
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);

    // SUB wraps to 0xFFFE with a borrow
    issue(3'b001, 3'd4, 3'd1, 3'd2);
    repeat (5) @(negedge clk);
    check("t2_r4", bank_mem[4], 16'hFFFE); check("t2_result", result, 16'hFFFE);
`ifdef REG_XFER_FLAGS_EN
    check("t2_flag_c", flag_c, 1'b1); check("t2_flag_z", flag_z, 1'b0);
`endif

    // rd aliases rs1: old value used, sum wraps to zero
    issue(3'b000, 3'd5, 3'd5, 3'd6);
    repeat (5) @(negedge clk);
    check("t3_r5", bank_mem[5], 16'h0000); check("t3_done", done, 1'b1);
`ifdef REG_XFER_FLAGS_EN
    check("t3_flag_z", flag_z, 1'b1); check("t3_flag_c", flag_c, 1'b1);
`endif

    // start during RD2 is ignored
    issue(3'b100, 3'd0, 3'd1, 3'd2);
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; rd = 3'd7; rs1 = 3'd1; rs2 = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    check("t4_done_count", done_cnt, 1);
    check("t4_r0", bank_mem[0], 16'h0006); check("t4_r7", bank_mem[7], 16'h1234);

    // reset during WB before the write edge
    issue(3'b111, 3'd7, 3'd1, 3'd1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_wr_drop", bank_wr, 1'b0); check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    check("t5_no_done", done_cnt, 0); check("t5_r7", bank_mem[7], 16'h1234);

    // SHL with start held high: second op accepted in the done cycle
    preload(3'd1, 16'h8001);
    @(posedge clk); #1;
    start = 1'b1; op = 3'b110; rd = 3'd2; rs1 = 3'd1; rs2 = 3'd3;
    @(posedge clk); #1;
    repeat (5) @(negedge clk);
    check("t6_done", done, 1'b1); check("t6_idle", busy, 1'b0);
    check("t6_r2", bank_mem[2], 16'h0002);
`ifdef REG_XFER_FLAGS_EN
    check("t6_flag_c", flag_c, 1'b1); check("t6_flag_z", flag_z, 1'b0);
`endif
    @(negedge clk);
    check("t6_rearm_busy", busy, 1'b1); check("t6_rearm_addr", bank_addr, 3'd1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_done2", done, 1'b1); check("t6_r2_again", bank_mem[2], 16'h0002);

    // Remaining ops on R0=0x0006, R2=0x0002
    tbl_op[0] = 3'b010; tbl_exp[0] = 16'h0002;
    tbl_op[1] = 3'b011; tbl_exp[1] = 16'h0006;
    tbl_op[2] = 3'b101; tbl_exp[2] = 16'hFFF9;
    tbl_op[3] = 3'b111; tbl_exp[3] = 16'h0006;
    for (int i = 0; i < 4; i++) begin
      issue(tbl_op[i], 3'd3, 3'd0, 3'd2);
      repeat (5) @(negedge clk);
      check("t7_r3", bank_mem[3], tbl_exp[i]);
      check("t7_result", result, tbl_exp[i]);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
- Register-transfer sequencer that sits directly in front of the 8x16 register bank and drives its single shared address, read-enable, write-enable and write-data lines.
- Per accepted operation:
  - reads source register rs1, then rs2, through the bank's one read port;
  - computes a 16-bit ALU result;
  - writes the result back to rd.
- Gives the datapath a three-operand instruction interface over a one-port bank.

Parameters:
- WIDTH, 16, data width; matches bank register width.
- AW, 3, register address width (2**AW registers).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code, captured on accept.
- rd  input  AW  destination register, captured on accept.
- rs1  input  AW  source A register, captured on accept.
- rs2  input  AW  source B register, captured on accept.
- bank_rdata  input  WIDTH  read data from bank (combinational from bank_addr while bank_rd=1).
- bank_addr  output  AW  shared read/write address to bank.
- bank_rd  output  1  bank read enable.
- bank_wr  output  1  bank write enable; bank writes bank_wdata at the rising edge while high.
- bank_wdata  output  WIDTH  write data to bank.
- result  output  WIDTH  last computed result; holds until the next EXEC.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after write-back.

Behaviour:
- Reset: asynchronous, active-high. Forces:
  - state = IDLE;
  - bank_addr = 0, bank_rd = 0, bank_wr = 0, bank_wdata = 0;
  - result = 0, busy = 0, done = 0;
  - internal A, B and captured fields = 0.
- FSM states: IDLE, RD1, RD2, EXEC, WB.
  - IDLE: if start=1, capture op/rd/rs1/rs2 and go to RD1. Otherwise stay.
  - RD1: bank_addr=rs1, bank_rd=1. At the edge, A <= bank_rdata. Go to RD2.
  - RD2: bank_addr=rs2, bank_rd=1. At the edge, B <= bank_rdata. Go to EXEC.
  - EXEC: bank_rd=0, bank_wr=0. At the edge, result <= f(op,A,B). Go to WB.
  - WB: bank_addr=rd, bank_wr=1, bank_wdata=result. Bank writes at this edge. Go to IDLE; done=1 for the following cycle.
- Outputs bank_addr, bank_rd and bank_wr are decoded from registered state and captured fields; they are glitch-free within a cycle.
- Latency: start sampled at edge 0; the write occurs at edge 4; done is high between edges 4 and 5. Back-to-back throughput is one op per 5 cycles.
- start while busy=1 is ignored: not queued, no field capture.
- start asserted in the same cycle that done is high is accepted normally.
- ALU, modulo 2**WIDTH, carries discarded:
  - 000 ADD: A+B.
  - 001 SUB: A-B (two's complement).
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 NOT: ~A.
  - 110 SHL: A<<1, LSB filled with 0.
  - 111 MOV: A.
  - Unary ops still perform the RD2 cycle; timing is uniform.
- rd equal to rs1 and/or rs2: legal. Sources are read before the write, so the old values are used.
- rs1 == rs2: both reads return the same register value.
- Reset mid-operation: bank_wr drops immediately (asynchronously) and no write occurs, even if reset is asserted during WB before the edge. The FSM resumes in IDLE after reset deasserts.
- done is never asserted without a completed write.

Optional Feature:
- Macro: REG_XFER_FLAGS_EN.
- Defined:
  - Adds output ports flag_z (1 bit) and flag_c (1 bit), both registered at EXEC together with result, and reset to 0.
  - flag_z = (result==0).
  - flag_c = carry-out of ADD, borrow of SUB (A<B unsigned), bit WIDTH-1 of A for SHL, and 0 for all other ops.
  - Flags hold until the next EXEC.
- Not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Preload bank R1=0x0003, R2=0x0005; start op=000 rd=3 rs1=1 rs2=2 → bank_addr 1,2,–,3 over 4 cycles; R3=0x0008 at edge 4; done pulses one cycle; busy high for 4 cycles.
- R1=0x0003, R2=0x0005, op=001 rd=4 rs1=1 rs2=2 → R4=0xFFFE; with REG_XFER_FLAGS_EN, flag_c=1 and flag_z=0.
- R5=0xFFFF, R6=0x0001, op=000 rd=5 rs1=5 rs2=6 → R5=0x0000 (aliasing uses the old value); with flags, flag_z=1 and flag_c=1.
- Pulse start during RD2 with different fields → ignored; only one write, to the original rd; exactly one done.
- Assert reset in the WB cycle before the edge, with op=111 rd=7 rs1=1 (R7=0x1234 beforehand) → bank_wr falls immediately, R7 stays 0x1234, done=0, busy=0.
- op=110 with R1=0x8001, rd=2; then start held high continuously → R2=0x0002, and the second op starts the cycle done is high (period 5 cycles).
